// File: rtl/nabp_angle_sequencer.sv
// Angle sequencer for NABP back-projection: hands out one projection angle per
// swap-control request, kicks the matching filtered-line load, and reports set completion.
module nabp_angle_sequencer #(
  parameter int ANGLE_WIDTH = 8,
  parameter int ANGLE_STEP  = 1,
  parameter int ANGLE_COUNT = 180
) (
  input  logic                   clk_out,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   next_angle,
  input  logic                   pr_done,
  output logic [ANGLE_WIDTH-1:0] angle,
  output logic                   has_next_angle,
  output logic                   next_angle_ack,
  output logic                   line_kick,
  output logic [ANGLE_WIDTH-1:0] line_index,
  output logic                   busy,
  output logic                   done
);

  // Counters must hold ANGLE_COUNT itself, which can reach 2^ANGLE_WIDTH.
  localparam int CLOG = $clog2(ANGLE_COUNT + 1);
  localparam int CW   = (CLOG > ANGLE_WIDTH) ? CLOG : ANGLE_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  state_e                 state_q;
  logic [ANGLE_WIDTH-1:0] angle_q;
  logic [ANGLE_WIDTH-1:0] line_index_q;
  logic [CW-1:0]          idx_q;
  logic [CW-1:0]          remaining_q;
  logic                   line_kick_q;
  logic                   done_q;
  logic                   has_next;

  // Handshake outputs are gated by reset_n so they read idle while reset is held.
  assign has_next       = reset_n && (state_q == ACTIVE) && (remaining_q != '0);
  assign has_next_angle = has_next;
  assign next_angle_ack = next_angle && has_next;
  assign busy           = reset_n && ((state_q == ACTIVE) || (state_q == DRAIN));
  assign angle          = angle_q;
  assign line_kick      = line_kick_q;
  assign line_index     = line_index_q;
  assign done           = done_q;

  always_ff @(posedge clk_out) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      angle_q      <= '0;
      line_index_q <= '0;
      line_kick_q  <= 1'b0;
      done_q       <= 1'b0;
      idx_q        <= '0;
      remaining_q  <= '0;
    end else begin
      line_kick_q <= next_angle_ack;
      done_q      <= 1'b0;
      if (next_angle_ack) begin
        line_index_q <= idx_q[ANGLE_WIDTH-1:0];
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            angle_q     <= '0;
            idx_q       <= '0;
            remaining_q <= CW'(ANGLE_COUNT);
            state_q     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (next_angle_ack) begin
            angle_q     <= angle_q + ANGLE_WIDTH'(ANGLE_STEP);
            idx_q       <= idx_q + CW'(1);
            remaining_q <= remaining_q - CW'(1);
            if (remaining_q == CW'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pr_done) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_out) begin
    if (reset_n && !(state_q inside {IDLE, ACTIVE, DRAIN})) begin
      $display("nabp_angle_sequencer: illegal state value %b", state_q);
    end
  end
`endif

endmodule
